ram_access_sequencer: RTL
=========================

RAM_ACCESS_SEQUENCER -- requirements
Module: ram_access_sequencer

Interface
REQ-001 Parameter IMG_WORDS, default 4096, sets the number of image words loaded and dumped (1..65536).
REQ-002 Parameter WDT_CYCLES, default 1000000, sets the RUN watchdog limit in clk cycles.
REQ-003 clk  in  1  sole clock; all state is updated on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 start  in  1  single-cycle pulse; begins a load/run/dump job.
REQ-006 host_wdata  in  16 / host_wvalid  in  1 / host_wready  out  1  form the image-load stream.
REQ-007 host_rdata  out  16 / host_rvalid  out  1 / host_rready  in  1  form the result-dump stream.
REQ-008 proc_addr  in  16 / proc_wdata  in  16 / proc_we  in  1 / proc_en  in  1  carry the processor RAM request.
REQ-009 proc_eop  in  1  is the processor End_of_process flag.
REQ-010 proc_run  out  1  is the processor release: 1 = execute, 0 = held.
REQ-011 proc_rdata  out  16  is the RAM read data returned to the processor.
REQ-012 ram_addr  out  16 / ram_wdata  out  16 / ram_we  out  1 / ram_en  out  1 / ram_rdata  in  16  form the shared single-port RAM port, which has synchronous read with 1-cycle latency.
REQ-013 busy / done / error  out  1 each  report job status.

Function
REQ-014 FSM states: IDLE, LOAD, RUN, DUMP_RD, DUMP_HOLD, DONE.
REQ-015 IDLE -> LOAD on start; start is ignored in every other state.
REQ-016 LOAD: host_wready=1; each cycle with host_wvalid=1 drives ram_en=1, ram_we=1, ram_addr=cnt, ram_wdata=host_wdata, then cnt++.
REQ-017 LOAD -> RUN after the write at cnt=IMG_WORDS-1; cnt then clears to 0.
REQ-018 RUN: proc_run=1; ram_* mirror the proc_* inputs combinationally; proc_rdata=ram_rdata.
REQ-019 RUN -> DUMP_RD on the first cycle with proc_eop=1; proc_run drops to 0 on that same edge.
REQ-020 DUMP_RD: ram_en=1, ram_we=0, ram_addr=cnt, then -> DUMP_HOLD.
REQ-021 DUMP_HOLD: on entry the FSM captures ram_rdata into host_rdata and asserts host_rvalid; host_rdata stays stable until host_rready=1.
REQ-022 DUMP_HOLD exit on handshake: to DUMP_RD with cnt++ if cnt<IMG_WORDS-1, else to DONE.
REQ-023 DONE: done=1 for exactly one cycle, then -> IDLE.
REQ-024 The host never reaches the RAM outside LOAD/DUMP, and the processor never reaches it outside RUN; ram_* are 0 in IDLE and DONE.
REQ-025 busy=1 in all states except IDLE.
REQ-026 cnt is 17-bit internally; ram_addr takes cnt[15:0]; IMG_WORDS=65536 ends at address 0xFFFF with no wrap.
REQ-027 host_wvalid outside LOAD is ignored; host_wready is 0 there.
REQ-028 proc_eop held high across a later job must not skip RUN; the RUN exit requires a proc_eop observed after entering RUN.

Reset
REQ-029 While rst_n=0: state=IDLE, cnt=0, and every output is 0 (proc_run, host_wready, host_rvalid, host_rdata, ram_*, busy, done, error).
REQ-030 Reset mid-job aborts immediately with no completion of a pending write; the first post-reset start begins a fresh LOAD at address 0.

Configuration
REQ-031 Macro RAM_SEQ_WATCHDOG_EN.
REQ-032 When RAM_SEQ_WATCHDOG_EN is defined:
- a RUN cycle counter starts at RUN entry;
- on reaching WDT_CYCLES without proc_eop, the FSM forces proc_run=0 and sets error=1 (sticky until reset or next start);
- the FSM then proceeds to DUMP_RD.
REQ-033 When RAM_SEQ_WATCHDOG_EN is undefined: no counter exists, error is tied to 0, and RUN waits indefinitely for proc_eop.

Verification
REQ-034 IMG_WORDS=4, start, host writes 0x1111..0x4444 with wvalid always high -> RAM addresses 0..3 hold the values and RUN is entered on the cycle after the last write.
REQ-035 During RUN, proc_en=1, proc_we=1, proc_addr=0x0002, proc_wdata=0xABCD -> RAM[2]=0xABCD; a host_wvalid pulse in the same cycle has no effect.
REQ-036 proc_eop pulse -> proc_run=0 next cycle; dump with host_rready held low 5 cycles -> host_rdata stable at RAM[0] with host_rvalid=1; 4 words emitted, then done=1 for one cycle.
REQ-037 rst_n=0 asserted during DUMP_HOLD at cnt=2 -> all outputs 0 asynchronously; a new start rewrites address 0.
REQ-038 With RAM_SEQ_WATCHDOG_EN defined, WDT_CYCLES=16 and proc_eop never asserted -> error=1 and proc_run=0 after 16 RUN cycles, and the dump still completes.
REQ-039 IMG_WORDS=65536 full load -> last write at 0xFFFF, with no write to address 0 after it.

Source files
------------

// File: rtl/ram_access_sequencer.sv
// ram_access_sequencer
//   Sequences one job on a shared single-port RAM. The host first streams
//   IMG_WORDS words into the RAM (LOAD). The processor is then released and
//   owns the RAM until it raises End_of_process (RUN). Finally the RAM
//   contents are streamed back to the host one word per handshake
//   (DUMP_RD/DUMP_HOLD), and a one-cycle done pulse closes the job.
//
//   Optional build macro: RAM_SEQ_WATCHDOG_EN
//     When defined, RUN is bounded to WDT_CYCLES clock cycles. On expiry
//     the processor is held, error is set (sticky until reset or the next
//     start) and the dump proceeds as usual. When undefined, error is tied
//     low and RUN waits for proc_eop indefinitely.
//
//   state     | meaning
//   ----------+--------------------------------------------------------
//   IDLE      | waiting for start, RAM port parked at zero
//   LOAD      | host image words written to RAM at address cnt
//   RUN       | processor released, RAM port mirrors the proc_* request
//   DUMP_RD   | RAM read issued at address cnt
//   DUMP_HOLD | read word captured and offered to the host until accepted
//   DONE      | done pulse for one cycle, then back to IDLE

module ram_access_sequencer #(
  parameter int IMG_WORDS  = 4096,
  parameter int WDT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] host_wdata,
  input  logic        host_wvalid,
  output logic        host_wready,
  output logic [15:0] host_rdata,
  output logic        host_rvalid,
  input  logic        host_rready,
  input  logic [15:0] proc_addr,
  input  logic [15:0] proc_wdata,
  input  logic        proc_we,
  input  logic        proc_en,
  input  logic        proc_eop,
  output logic        proc_run,
  output logic [15:0] proc_rdata,
  output logic [15:0] ram_addr,
  output logic [15:0] ram_wdata,
  output logic        ram_we,
  output logic        ram_en,
  input  logic [15:0] ram_rdata,
  output logic        busy,
  output logic        done,
  output logic        error
);

  // Reject parameter values the 16-bit address space and the watchdog
  // counter cannot represent.
  if (IMG_WORDS < 1 || IMG_WORDS > 65536) begin : g_bad_img_words
    $error("ram_access_sequencer: IMG_WORDS must be in 1..65536");
  end
  if (WDT_CYCLES < 1) begin : g_bad_wdt_cycles
    $error("ram_access_sequencer: WDT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    RUN       = 3'd2,
    DUMP_RD   = 3'd3,
    DUMP_HOLD = 3'd4,
    DONE      = 3'd5
  } state_t;

  // cnt is one bit wider than the address so IMG_WORDS=65536 has a
  // representable last index (0xFFFF) without any wrap arithmetic.
  localparam logic [16:0] LAST_IDX = 17'(IMG_WORDS - 1);

  state_t      state;
  logic [16:0] cnt;
  logic        rd_captured;
  // Set when proc_eop was already high as RUN was entered; a stale level
  // from an earlier job must fall before it can end this RUN phase.
  logic        eop_stale;
  logic        eop_exit;
  logic        wdt_expire;

  assign eop_exit = proc_eop && !eop_stale;

`ifdef RAM_SEQ_WATCHDOG_EN
  localparam int               WDT_W    = $clog2(WDT_CYCLES + 1);
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

  logic [WDT_W-1:0] wdt_cnt;

  // wdt_cnt counts completed RUN cycles; the last allowed cycle ends RUN.
  assign wdt_expire = (wdt_cnt == WDT_LAST);
`else
  assign wdt_expire = 1'b0;
  assign error      = 1'b0;
`endif

  // Job sequencing FSM with all status/handshake outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      rd_captured <= 1'b0;
      eop_stale   <= 1'b0;
      proc_run    <= 1'b0;
      host_wready <= 1'b0;
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
`ifdef RAM_SEQ_WATCHDOG_EN
      wdt_cnt     <= '0;
      error       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= LOAD;
            cnt         <= '0;
            host_wready <= 1'b1;
            busy        <= 1'b1;
`ifdef RAM_SEQ_WATCHDOG_EN
            error       <= 1'b0;
`endif
          end
        end

        LOAD: begin
          if (host_wvalid) begin
            if (cnt == LAST_IDX) begin
              state       <= RUN;
              cnt         <= '0;
              host_wready <= 1'b0;
              proc_run    <= 1'b1;
              eop_stale   <= proc_eop;
`ifdef RAM_SEQ_WATCHDOG_EN
              wdt_cnt     <= '0;
`endif
            end else begin
              cnt <= cnt + 17'd1;
            end
          end
        end

        RUN: begin
          if (eop_exit || wdt_expire) begin
            state     <= DUMP_RD;
            proc_run  <= 1'b0;
            eop_stale <= 1'b0;
`ifdef RAM_SEQ_WATCHDOG_EN
            if (!eop_exit) begin
              error <= 1'b1;
            end
`endif
          end else begin
            if (!proc_eop) begin
              eop_stale <= 1'b0;
            end
`ifdef RAM_SEQ_WATCHDOG_EN
            wdt_cnt <= wdt_cnt + 1'b1;
`endif
          end
        end

        DUMP_RD: begin
          state       <= DUMP_HOLD;
          rd_captured <= 1'b0;
        end

        // The RAM word read in DUMP_RD is valid during the first HOLD
        // cycle; it is latched once so host_rdata cannot change while the
        // host stalls.
        DUMP_HOLD: begin
          if (!rd_captured) begin
            host_rdata  <= ram_rdata;
            host_rvalid <= 1'b1;
            rd_captured <= 1'b1;
          end else if (host_rready) begin
            host_rvalid <= 1'b0;
            if (cnt < LAST_IDX) begin
              cnt   <= cnt + 17'd1;
              state <= DUMP_RD;
            end else begin
              cnt   <= '0;
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // RAM port ownership: host in LOAD/DUMP_RD, processor in RUN, parked
  // at zero otherwise (including during reset, since state is IDLE).
  always_comb begin
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;
    proc_rdata = '0;
    case (state)
      LOAD: begin
        if (host_wvalid) begin
          ram_en    = 1'b1;
          ram_we    = 1'b1;
          ram_addr  = cnt[15:0];
          ram_wdata = host_wdata;
        end
      end
      RUN: begin
        ram_en     = proc_en;
        ram_we     = proc_we;
        ram_addr   = proc_addr;
        ram_wdata  = proc_wdata;
        proc_rdata = ram_rdata;
      end
      DUMP_RD: begin
        ram_en   = 1'b1;
        ram_addr = cnt[15:0];
      end
      default: begin
      end
    endcase
  end

endmodule
